test_and_tc: RTL and testbench
==============================

# test_and_tc

Clocked two-input AND cell with built-in timing checks. The block registers `out = a & b` and watches each rising edge of `out`. It flags setup violations when an input changed too shortly before the edge, and hold violations when an input changes too shortly after it. It sits in gate-level characterisation benches as a synthesizable stand-in for a timing-annotated AND primitive, giving cycle-accurate violation reporting without SDF.

## Interface
- `SETUP_A`, 5: minimum quiet cycles on `a` before a rising edge of `out`.
- `SETUP_B`, 8: minimum quiet cycles on `b` before a rising edge of `out`.
- `HOLD_A`, 5: minimum quiet cycles on `a` after a rising edge of `out`.
- `HOLD_B`, 5: minimum quiet cycles on `b` after a rising edge of `out`.
- `CW`, 8: width of the age and violation counters.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset is synchronous and active-low.
- `a` input 1: AND operand A, sampled every cycle.
- `b` input 1: AND operand B, sampled every cycle.
- `out` output 1: registered `a & b`.
- `setup_viol_a` output 1: one-cycle pulse; setup violation on A.
- `setup_viol_b` output 1: one-cycle pulse; setup violation on B.
- `hold_viol_a` output 1: one-cycle pulse; hold violation on A.
- `hold_viol_b` output 1: one-cycle pulse; hold violation on B.
- `viol_cnt` output CW: total violations, saturating; present only with the macro.

## Operation
- Input registers: `a_q <= a` and `b_q <= b`. A change on A in cycle n means `a` sampled at n differs from `a_q`. B is defined the same way.
- Output: `out <= a & b`.
- Edge: a rising edge of `out` occurs in cycle n when `a & b` = 1 and `out` = 0.
- Age counters `age_a` and `age_b`:
  - The counter clears to 0 in a cycle where its input changes.
  - Otherwise it increments each cycle, saturating at 2^CW−1.
- Setup check, evaluated at the edge cycle:
  - An input that changes in the edge cycle itself triggered the edge and is not setup-checked.
  - Otherwise, `setup_viol_x` pulses if `age_x + 1 < SETUP_X`, i.e. the input's last change was fewer than SETUP_X cycles before the edge.
- Hold window:
  - An edge opens a hold window and loads counter `hold_cnt` with max(HOLD_A, HOLD_B).
  - The window covers the cycles 1..HOLD_X after the edge.
  - `hold_viol_x` pulses in the cycle in which X changes inside its window.
  - Each input flags at most once per window.
- A new edge while the window is open reloads the window and clears the once-per-window flags.
- Simultaneous events: violations on A and B in the same cycle both pulse. A setup and a hold violation in the same cycle both pulse.

## Timing
- Latency from `a`/`b` to `out`: 1 cycle.
- Violation pulses are registered. They assert the cycle after the offending sample and last exactly 1 cycle.
- Reset state (`rst_n` = 0 at a clock edge):
  - `out` = 0, all violation pulses = 0, `viol_cnt` = 0.
  - `a_q` and `b_q` = 0.
  - Age counters saturate at max, so there are no false setup violations after reset.
  - The hold window is closed.
- Reset mid-window: the window aborts and no violation is reported for that window.

## Configuration
- Macro `TEST_AND_VIOL_CNT_EN`.
- Defined:
  - `viol_cnt` port exists.
  - It increments by the number of violation pulses in each cycle (0..4).
  - It saturates at 2^CW−1.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Clean edge: after reset `a`=`b`=0; `a`=1, then 20 cycles later `b`=1 → `out` rises 1 cycle later; no violation pulses.
- Setup B: `a`=0, `b`=1, then 2 cycles later `a`=1 → edge caused by A; `setup_viol_b` pulses once (age 2 < 8); `setup_viol_a` stays 0.
- Hold A: `a`=1 held, `b`=1 (edge), then 2 cycles later `a`=0 → `hold_viol_a` pulses once; `out` falls.
- Hold B: `a`=1 held, `b`=1, then 3 cycles later `b`=0 → `hold_viol_b` pulses once; `hold_viol_a` stays 0.
- Window boundary: after an edge, `a` changes 6 cycles later → no hold pulse. Repeat with `a` changing 1 cycle later → `hold_viol_a` pulses.
- Reset and counter: provoke 3 violations → `viol_cnt`=3 (macro on). Assert `rst_n`=0 in the middle of a hold window → all outputs 0 and no late pulse.

Source files
------------

// File: rtl/test_and_tc.sv
// rtl/test_and_tc.sv - registered AND cell with setup/hold violation detection (optional TEST_AND_VIOL_CNT_EN violation counter)
module test_and_tc #(
    parameter int SETUP_A = 5,
    parameter int SETUP_B = 8,
    parameter int HOLD_A  = 5,
    parameter int HOLD_B  = 5,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a,
    input  logic          b,
    output logic          out,
    output logic          setup_viol_a,
    output logic          setup_viol_b,
    output logic          hold_viol_a,
    output logic          hold_viol_b
`ifdef TEST_AND_VIOL_CNT_EN
    ,
    output logic [CW-1:0] viol_cnt
`endif
);

    localparam int HOLD_MAX = (HOLD_A > HOLD_B) ? HOLD_A : HOLD_B;
    localparam int HW       = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [CW:0] SETUP_A_W = (CW+1)'(SETUP_A);
    localparam logic [CW:0] SETUP_B_W = (CW+1)'(SETUP_B);

    logic          a_q, a_d, b_q, b_d, out_q, out_d;
    logic [CW-1:0] age_a_q, age_a_d, age_b_q, age_b_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          flag_a_q, flag_a_d, flag_b_q, flag_b_d;
    logic          sva_q, sva_d, svb_q, svb_d, hva_q, hva_d, hvb_q, hvb_d;
    logic          chg_a, chg_b, rise, win_open, in_win_a, in_win_b;

    always_comb begin
        chg_a    = a ^ a_q;
        chg_b    = b ^ b_q;
        rise     = a & b & ~out_q;
        a_d      = a;
        b_d      = b;
        out_d    = a & b;
        age_a_d  = chg_a ? '0 : ((age_a_q == '1) ? age_a_q : age_a_q + 1'b1);
        age_b_d  = chg_b ? '0 : ((age_b_q == '1) ? age_b_q : age_b_q + 1'b1);
        // hold_cnt counts down from HOLD_MAX, so offset after the edge is HOLD_MAX - hold_cnt + 1
        win_open = (hold_cnt_q != '0);
        in_win_a = win_open && (int'(hold_cnt_q) > HOLD_MAX - HOLD_A);
        in_win_b = win_open && (int'(hold_cnt_q) > HOLD_MAX - HOLD_B);
        sva_d    = rise & ~chg_a & (({1'b0, age_a_q} + 1'b1) < SETUP_A_W);
        svb_d    = rise & ~chg_b & (({1'b0, age_b_q} + 1'b1) < SETUP_B_W);
        hva_d    = chg_a & in_win_a & ~flag_a_q;
        hvb_d    = chg_b & in_win_b & ~flag_b_q;
        // a change in the edge cycle belongs to the old window; the new edge then clears the flags
        flag_a_d = rise ? 1'b0 : (flag_a_q | hva_d);
        flag_b_d = rise ? 1'b0 : (flag_b_q | hvb_d);
        hold_cnt_d = rise ? HW'(HOLD_MAX) : (win_open ? hold_cnt_q - 1'b1 : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            out_q      <= 1'b0;
            age_a_q    <= '1;
            age_b_q    <= '1;
            hold_cnt_q <= '0;
            flag_a_q   <= 1'b0;
            flag_b_q   <= 1'b0;
            sva_q      <= 1'b0;
            svb_q      <= 1'b0;
            hva_q      <= 1'b0;
            hvb_q      <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            out_q      <= out_d;
            age_a_q    <= age_a_d;
            age_b_q    <= age_b_d;
            hold_cnt_q <= hold_cnt_d;
            flag_a_q   <= flag_a_d;
            flag_b_q   <= flag_b_d;
            sva_q      <= sva_d;
            svb_q      <= svb_d;
            hva_q      <= hva_d;
            hvb_q      <= hvb_d;
        end
    end

    assign out          = out_q;
    assign setup_viol_a = sva_q;
    assign setup_viol_b = svb_q;
    assign hold_viol_a  = hva_q;
    assign hold_viol_b  = hvb_q;

`ifdef TEST_AND_VIOL_CNT_EN
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    n_viol;
    logic [CW:0]   cnt_sum;

    // counts the pulses being registered this cycle so the count tracks the visible pulses
    always_comb begin
        n_viol  = 3'(sva_d) + 3'(svb_d) + 3'(hva_d) + 3'(hvb_d);
        cnt_sum = {1'b0, cnt_q} + (CW+1)'(n_viol);
        cnt_d   = cnt_sum[CW] ? '1 : cnt_sum[CW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign viol_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_test_and_tc.sv
// tb/tb_test_and_tc.sv - self-checking bench for test_and_tc against a timestamp-based reference model
module tb_test_and_tc;
    localparam int SA = 5, SB = 8, HA = 5, HB = 5, CW = 8;
    localparam int FAR = -100000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a = 1'b0, b = 1'b0;
    logic out, setup_viol_a, setup_viol_b, hold_viol_a, hold_viol_b;
`ifdef TEST_AND_VIOL_CNT_EN
    logic [CW-1:0] viol_cnt;
`endif

    test_and_tc #(.SETUP_A(SA), .SETUP_B(SB), .HOLD_A(HA), .HOLD_B(HB), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .out(out),
        .setup_viol_a(setup_viol_a), .setup_viol_b(setup_viol_b),
        .hold_viol_a(hold_viol_a), .hold_viol_b(hold_viol_b)
`ifdef TEST_AND_VIOL_CNT_EN
        , .viol_cnt(viol_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    // model state: previous inputs, cycle index, timestamps of last change and last rising edge
    int t = 0, lc_a = FAR, lc_b = FAR, le = FAR;
    logic pa = 0, pb = 0, m_out = 0, fa = 0, fb = 0;
    logic e_sa = 0, e_sb = 0, e_ha = 0, e_hb = 0;
    int m_cnt = 0;
    int n_sa = 0, n_sb = 0, n_ha = 0, n_hb = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ai, input logic bi, input logic rn);
        logic ca, cb, r;
        @(negedge clk);
        a = ai; b = bi; rst_n = rn;
        if (!rn) begin
            pa = 0; pb = 0; m_out = 0; fa = 0; fb = 0;
            lc_a = FAR; lc_b = FAR; le = FAR; m_cnt = 0;
            e_sa = 0; e_sb = 0; e_ha = 0; e_hb = 0;
        end else begin
            ca = (ai != pa);
            cb = (bi != pb);
            r  = ai & bi & ~m_out;
            e_sa = r && !ca && (t - lc_a) < SA;
            e_sb = r && !cb && (t - lc_b) < SB;
            e_ha = ca && (t - le) >= 1 && (t - le) <= HA && !fa;
            e_hb = cb && (t - le) >= 1 && (t - le) <= HB && !fb;
            fa = r ? 1'b0 : (fa | e_ha);
            fb = r ? 1'b0 : (fb | e_hb);
            if (r)  le = t;
            if (ca) lc_a = t;
            if (cb) lc_b = t;
            m_out = ai & bi;
            pa = ai; pb = bi;
            m_cnt = m_cnt + int'(e_sa) + int'(e_sb) + int'(e_ha) + int'(e_hb);
            if (m_cnt > 2**CW - 1) m_cnt = 2**CW - 1;
        end
        t++;
        @(posedge clk);
        #1;
        chk("out", 32'(out), 32'(m_out));
        chk("setup_viol_a", 32'(setup_viol_a), 32'(e_sa));
        chk("setup_viol_b", 32'(setup_viol_b), 32'(e_sb));
        chk("hold_viol_a", 32'(hold_viol_a), 32'(e_ha));
        chk("hold_viol_b", 32'(hold_viol_b), 32'(e_hb));
`ifdef TEST_AND_VIOL_CNT_EN
        chk("viol_cnt", 32'(viol_cnt), 32'(m_cnt));
`endif
        n_sa += int'(setup_viol_a); n_sb += int'(setup_viol_b);
        n_ha += int'(hold_viol_a);  n_hb += int'(hold_viol_b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic hold_ab(input logic ai, input logic bi, input int n);
        for (int i = 0; i < n; i++) step(ai, bi, 1'b1);
    endtask

    int s0, s1, h0, h1;
    logic ra, rb;

    initial begin
        // reset state
        step(1, 1, 0);
        step(0, 0, 0);
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_pulses", 32'({setup_viol_a, setup_viol_b, hold_viol_a, hold_viol_b}), 32'd0);
        idle(3);

        // clean edge
        s0 = n_sa + n_sb + n_ha + n_hb;
        hold_ab(1, 0, 21);
        step(1, 1, 1);
        chk("clean_out_rise", 32'(out), 32'd1);
        hold_ab(1, 1, 10);
        idle(20);
        chk("clean_no_viol", 32'(n_sa + n_sb + n_ha + n_hb - s0), 32'd0);

        // setup on B
        s0 = n_sa; s1 = n_sb;
        hold_ab(0, 1, 2);
        step(1, 1, 1);
        chk("setupb_pulse", 32'(setup_viol_b), 32'd1);
        hold_ab(1, 1, 10);
        idle(20);
        chk("setupb_count", 32'(n_sb - s1), 32'd1);
        chk("setupb_a_quiet", 32'(n_sa - s0), 32'd0);

        // hold on A
        h0 = n_ha;
        hold_ab(1, 0, 20);
        hold_ab(1, 1, 2);
        step(0, 1, 1);
        chk("holda_pulse", 32'(hold_viol_a), 32'd1);
        chk("holda_out_fall", 32'(out), 32'd0);
        hold_ab(0, 1, 10);
        idle(20);
        chk("holda_count", 32'(n_ha - h0), 32'd1);

        // hold on B
        h0 = n_ha; h1 = n_hb;
        hold_ab(1, 0, 20);
        hold_ab(1, 1, 3);
        step(1, 0, 1);
        hold_ab(1, 0, 10);
        idle(20);
        chk("holdb_count", 32'(n_hb - h1), 32'd1);
        chk("holdb_a_quiet", 32'(n_ha - h0), 32'd0);

        // window boundary: change at offset 6 is outside, offset 1 is inside
        h0 = n_ha;
        hold_ab(1, 0, 20);
        hold_ab(0, 1, 20);
        hold_ab(1, 1, 6);
        step(0, 1, 1);
        chk("win_edge6", 32'(n_ha - h0), 32'd0);
        hold_ab(0, 1, 20);
        step(1, 1, 1);
        step(0, 1, 1);
        chk("win_edge1", 32'(hold_viol_a), 32'd1);
        hold_ab(0, 1, 10);
        idle(20);

        // three violations after reset, then reset in the middle of a window
        step(0, 0, 0);
        idle(20);
        hold_ab(0, 1, 2); step(1, 1, 1); hold_ab(1, 1, 10); idle(20);
        hold_ab(1, 0, 20); hold_ab(1, 1, 2); step(0, 1, 1); hold_ab(0, 1, 10); idle(20);
        hold_ab(1, 0, 20); hold_ab(1, 1, 3); step(1, 0, 1); hold_ab(1, 0, 10); idle(20);
`ifdef TEST_AND_VIOL_CNT_EN
        chk("viol_cnt_three", 32'(viol_cnt), 32'd3);
`endif
        hold_ab(1, 0, 20);
        step(1, 1, 1);
        step(1, 1, 1);
        step(0, 0, 0);
        chk("midrst_out", 32'(out), 32'd0);
        s0 = n_sa + n_sb + n_ha + n_hb;
        idle(8);
        chk("midrst_no_late", 32'(n_sa + n_sb + n_ha + n_hb - s0), 32'd0);

        // randomized traffic with occasional resets
        ra = 0; rb = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) ra = ~ra;
            if ($urandom_range(0, 6) == 0) rb = ~rb;
            if ($urandom_range(0, 599) == 0) begin
                step(ra, rb, 1'b0);
                ra = 0; rb = 0;
            end else begin
                step(ra, rb, 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
